// File: rtl/lsu_mem_adapter_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_adapter_if
// Bundles the three channels around the load/store adapter:
//   request  : i_req_valid / o_req_ready / i_req_we / i_req_funct3 /
//              i_req_addr / i_req_wdata              (core -> adapter)
//   response : o_rsp_valid / i_rsp_ready / o_rsp_rdata / o_rsp_err
//                                                     (adapter -> core)
//   memory   : o_mem_addr / o_mem_wr_data / o_mem_wr_en / o_mem_rd_en /
//              i_mem_rd_data                          (adapter <-> memory)
// The i_/o_ prefixes are from the adapter's point of view.
// modport slave  : the adapter itself.
// modport master : whoever surrounds it (core plus memory, or a testbench).
// ---------------------------------------------------------------------------
interface lsu_mem_adapter_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wr_data;
    logic [3:0]  o_mem_wr_en;
    logic        o_mem_rd_en;
    logic [31:0] i_mem_rd_data;

    modport slave (
        input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        output o_req_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  i_rsp_ready,
        output o_mem_addr, o_mem_wr_data, o_mem_wr_en, o_mem_rd_en,
        input  i_mem_rd_data
    );

    modport master (
        output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
        input  o_req_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output i_rsp_ready,
        input  o_mem_addr, o_mem_wr_data, o_mem_wr_en, o_mem_rd_en,
        output i_mem_rd_data
    );
endinterface

// File: rtl/lsu_mem_adapter.sv
// ---------------------------------------------------------------------------
// lsu_mem_adapter
// Load/store adapter between the core's data-access request channel and a
// single-ported word-wide data memory. One transaction is held at a time:
//   legal load  : accept -> rd_en pulse -> capture data -> response  (3 cycles)
//   legal store : accept -> wr_en pulse -> acknowledge               (2 cycles)
//   error       : accept -> error response, no memory access         (1 cycle)
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous reset, active low
//   bus    : lsu_mem_adapter_if.slave (request, response and memory channels)
//   o_stat_loads / o_stat_stores / o_stat_errs (32 bit, optional): handshake
//            counters, present only when LSU_ADAPTER_STATS_EN is defined.
//
// Parameter:
//   RD_BYTE_SWAP : 1 = memory returns the byte at word offset 0 in [31:24],
//                  so the read word is byte-reversed before lane selection.
//
// Optional build macro: LSU_ADAPTER_STATS_EN
// ---------------------------------------------------------------------------
module lsu_mem_adapter #(
    parameter int RD_BYTE_SWAP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lsu_mem_adapter_if.slave      bus
`ifdef LSU_ADAPTER_STATS_EN
    ,
    output logic [31:0]           o_stat_loads,
    output logic [31:0]           o_stat_stores,
    output logic [31:0]           o_stat_errs
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state;

    // Request fields needed after acceptance.
    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_off;

    logic        req_err;
    logic [3:0]  store_en;
    logic [31:0] store_data;

    logic [31:0] rd_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_result;

    // Request decode: illegal widths and misaligned halfword/word accesses.
    always_comb begin
        req_err = 1'b0;
        if (bus.i_req_we) begin
            case (bus.i_req_funct3)
                3'd0:    req_err = 1'b0;
                3'd1:    req_err = bus.i_req_addr[0];
                3'd2:    req_err = (bus.i_req_addr[1:0] != 2'b00);
                default: req_err = 1'b1;
            endcase
        end else begin
            case (bus.i_req_funct3)
                3'd0, 3'd4: req_err = 1'b0;
                3'd1, 3'd5: req_err = bus.i_req_addr[0];
                3'd2:       req_err = (bus.i_req_addr[1:0] != 2'b00);
                default:    req_err = 1'b1;
            endcase
        end
    end

    // Store lane enables, with the data replicated across lanes so the
    // enabled lane always carries the right byte or halfword.
    always_comb begin
        store_en   = 4'b0000;
        store_data = bus.i_req_wdata;
        case (bus.i_req_funct3)
            3'd0: begin
                store_en   = 4'b0001 << bus.i_req_addr[1:0];
                store_data = {4{bus.i_req_wdata[7:0]}};
            end
            3'd1: begin
                store_en   = bus.i_req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{bus.i_req_wdata[15:0]}};
            end
            default: begin
                store_en   = 4'b1111;
                store_data = bus.i_req_wdata;
            end
        endcase
    end

    // Load path: normalise byte order, pick the lane by the captured
    // offset, then sign- or zero-extend according to the captured width.
    always_comb begin
        rd_word = bus.i_mem_rd_data;
        if (RD_BYTE_SWAP != 0) begin
            rd_word = {bus.i_mem_rd_data[7:0],   bus.i_mem_rd_data[15:8],
                       bus.i_mem_rd_data[23:16], bus.i_mem_rd_data[31:24]};
        end

        case (cap_off)
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = cap_off[1] ? rd_word[31:16] : rd_word[15:0];

        case (cap_funct3)
            3'd0:    load_result = {{24{sel_byte[7]}}, sel_byte};
            3'd1:    load_result = {{16{sel_half[15]}}, sel_half};
            3'd2:    load_result = rd_word;
            3'd4:    load_result = {24'd0, sel_byte};
            3'd5:    load_result = {16'd0, sel_half};
            default: load_result = 32'd0;
        endcase
    end

    // Transaction FSM. Memory strobes default low every cycle so they can
    // only ever be a single-cycle pulse out of the accepting IDLE edge.
    // o_req_ready is re-armed every IDLE cycle, which leaves it low for the
    // first cycle after reset and high once the FSM is settled in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cap_we            <= 1'b0;
            cap_funct3        <= 3'd0;
            cap_off           <= 2'd0;
            bus.o_req_ready   <= 1'b0;
            bus.o_rsp_valid   <= 1'b0;
            bus.o_rsp_rdata   <= 32'd0;
            bus.o_rsp_err     <= 1'b0;
            bus.o_mem_addr    <= 32'd0;
            bus.o_mem_wr_data <= 32'd0;
            bus.o_mem_wr_en   <= 4'd0;
            bus.o_mem_rd_en   <= 1'b0;
        end else begin
            bus.o_mem_wr_en <= 4'd0;
            bus.o_mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    bus.o_req_ready <= 1'b1;
                    if (bus.i_req_valid && bus.o_req_ready) begin
                        bus.o_req_ready <= 1'b0;
                        cap_we          <= bus.i_req_we;
                        cap_funct3      <= bus.i_req_funct3;
                        cap_off         <= bus.i_req_addr[1:0];
                        if (req_err) begin
                            state           <= RESP;
                            bus.o_rsp_valid <= 1'b1;
                            bus.o_rsp_err   <= 1'b1;
                            bus.o_rsp_rdata <= 32'd0;
                        end else begin
                            state          <= ISSUE;
                            bus.o_mem_addr <= {bus.i_req_addr[31:2], 2'b00};
                            if (bus.i_req_we) begin
                                bus.o_mem_wr_en   <= store_en;
                                bus.o_mem_wr_data <= store_data;
                            end else begin
                                bus.o_mem_rd_en <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (cap_we) begin
                        state           <= RESP;
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_rsp_err   <= 1'b0;
                        bus.o_rsp_rdata <= 32'd0;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    state           <= RESP;
                    bus.o_rsp_valid <= 1'b1;
                    bus.o_rsp_err   <= 1'b0;
                    bus.o_rsp_rdata <= load_result;
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        state           <= IDLE;
                        bus.o_rsp_valid <= 1'b0;
                        bus.o_rsp_err   <= 1'b0;
                        bus.o_rsp_rdata <= 32'd0;
                        bus.o_req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_ADAPTER_STATS_EN
    // Handshake counters; an error response counts only as an error even
    // though the captured request was a load or a store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stat_loads  <= 32'd0;
            o_stat_stores <= 32'd0;
            o_stat_errs   <= 32'd0;
        end else if (bus.o_rsp_valid && bus.i_rsp_ready) begin
            if (bus.o_rsp_err) begin
                o_stat_errs <= o_stat_errs + 32'd1;
            end else if (cap_we) begin
                o_stat_stores <= o_stat_stores + 32'd1;
            end else begin
                o_stat_loads <= o_stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_adapter
// Directed bench for lsu_mem_adapter with RD_BYTE_SWAP=1. The memory side
// returns 0xD4C3B2A1 only in the cycle after the read strobe, so a load
// captured on the wrong edge picks up 0x5A5A5A5A instead. Inputs are driven
// and outputs sampled on the falling clock edge.
// Optional build macro honoured: LSU_ADAPTER_STATS_EN
// ---------------------------------------------------------------------------
module tb_lsu_mem_adapter;

    logic clk;
    logic rst_n;

    lsu_mem_adapter_if bus ();

`ifdef LSU_ADAPTER_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errs;
`endif

    int n_checks;
    int n_fails;
    int pulse_cnt;
    int pulse_snap;

    lsu_mem_adapter #(.RD_BYTE_SWAP(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus)
`ifdef LSU_ADAPTER_STATS_EN
        ,
        .o_stat_loads  (stat_loads),
        .o_stat_stores (stat_stores),
        .o_stat_errs   (stat_errs)
`endif
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every cycle in which any memory strobe is asserted.
    always @(posedge clk) begin
        if (bus.o_mem_rd_en || (bus.o_mem_wr_en != 4'd0)) pulse_cnt++;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for o_req_ready; an expired bound shows up as a failure.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.o_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_req_ready"}, 32'(bus.o_req_ready), 32'd1);
    endtask

    // One complete transaction: accept, per-cycle checks up to the response
    // at latency 'lat', optional stall of 'hold' cycles (during which a
    // competing request is presented and must be ignored), then handshake.
    task automatic apply_stimulus(input string tag, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input int lat, input logic [3:0] exp_wr_en,
                                  input logic [31:0] exp_wr_data, input logic [31:0] exp_rdata,
                                  input logic exp_err, input int hold, input logic early);
        wait_ready(tag);
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = we;
        bus.i_req_funct3 = f3;
        bus.i_req_addr   = addr;
        bus.i_req_wdata  = wdata;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.i_req_valid = 1'b0;
                bus.i_req_addr  = 32'hDEAD_BEEF;
                bus.i_req_wdata = 32'h0BAD_F00D;
                if (early) bus.i_rsp_ready = 1'b1;
            end
            if (k == 1 && lat > 1) begin
                check_output({tag, "_mem_addr"}, bus.o_mem_addr, addr & 32'hFFFF_FFFC);
                check_output({tag, "_wr_en"}, 32'(bus.o_mem_wr_en), 32'(exp_wr_en));
                check_output({tag, "_rd_en"}, 32'(bus.o_mem_rd_en), 32'(!we));
                if (we) check_output({tag, "_wr_data"}, bus.o_mem_wr_data, exp_wr_data);
            end else begin
                check_output({tag, "_wr_en_idle"}, 32'(bus.o_mem_wr_en), 32'd0);
                check_output({tag, "_rd_en_idle"}, 32'(bus.o_mem_rd_en), 32'd0);
            end
            if (k == 2 && !we) bus.i_mem_rd_data = 32'hD4C3B2A1;
            if (k == 3) bus.i_mem_rd_data = 32'h5A5A5A5A;
            check_output({tag, "_req_ready_busy"}, 32'(bus.o_req_ready), 32'd0);
            if (k < lat) begin
                check_output({tag, "_rsp_early"}, 32'(bus.o_rsp_valid), 32'd0);
            end else begin
                check_output({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd1);
                check_output({tag, "_rdata"}, bus.o_rsp_rdata, exp_rdata);
                check_output({tag, "_err"}, 32'(bus.o_rsp_err), 32'(exp_err));
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (h == 0) begin
                bus.i_req_valid  = 1'b1;
                bus.i_req_we     = 1'b1;
                bus.i_req_funct3 = 3'd2;
                bus.i_req_addr   = 32'h0000_0040;
            end
            check_output({tag, "_hold_valid"}, 32'(bus.o_rsp_valid), 32'd1);
            check_output({tag, "_hold_rdata"}, bus.o_rsp_rdata, exp_rdata);
            check_output({tag, "_hold_ready"}, 32'(bus.o_req_ready), 32'd0);
            check_output({tag, "_hold_wr_en"}, 32'(bus.o_mem_wr_en), 32'd0);
        end
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        bus.i_req_valid = 1'b0;
        check_output({tag, "_rsp_drop"}, 32'(bus.o_rsp_valid), 32'd0);
        check_output({tag, "_ready_back"}, 32'(bus.o_req_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        pulse_cnt = 0;
        rst_n            = 1'b0;
        bus.i_req_valid  = 1'b0;
        bus.i_req_we     = 1'b0;
        bus.i_req_funct3 = 3'd0;
        bus.i_req_addr   = 32'd0;
        bus.i_req_wdata  = 32'd0;
        bus.i_rsp_ready  = 1'b0;
        bus.i_mem_rd_data = 32'h5A5A5A5A;

        // Reset state.
        @(negedge clk);
        #2;
        check_output("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
        check_output("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        check_output("rst_rdata", bus.o_rsp_rdata, 32'd0);
        check_output("rst_err", 32'(bus.o_rsp_err), 32'd0);
        check_output("rst_mem_addr", bus.o_mem_addr, 32'd0);
        check_output("rst_wr_en", 32'(bus.o_mem_wr_en), 32'd0);
        check_output("rst_rd_en", 32'(bus.o_mem_rd_en), 32'd0);
`ifdef LSU_ADAPTER_STATS_EN
        check_output("rst_stat_loads", stat_loads, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Stores: word, byte at lane 3, halfword upper with early rsp_ready.
        apply_stimulus("sw", 1'b1, 3'd2, 32'h10, 32'hA1B2C3D4, 2, 4'b1111, 32'hA1B2C3D4, 32'd0, 1'b0, 0, 1'b0);
        apply_stimulus("sb", 1'b1, 3'd0, 32'h13, 32'h000000EE, 2, 4'b1000, 32'hEEEEEEEE, 32'd0, 1'b0, 0, 1'b0);
        apply_stimulus("sh", 1'b1, 3'd1, 32'h16, 32'h1234BEEF, 2, 4'b1100, 32'hBEEFBEEF, 32'd0, 1'b0, 0, 1'b1);

        // Loads against word 0xD4C3B2A1 (byte-reversed to 0xA1B2C3D4).
        apply_stimulus("lb13", 1'b0, 3'd0, 32'h13, 32'd0, 3, 4'b0000, 32'd0, 32'hFFFFFFA1, 1'b0, 0, 1'b0);
        apply_stimulus("lbu13", 1'b0, 3'd4, 32'h13, 32'd0, 3, 4'b0000, 32'd0, 32'h000000A1, 1'b0, 0, 1'b0);
        apply_stimulus("lh12", 1'b0, 3'd1, 32'h12, 32'd0, 3, 4'b0000, 32'd0, 32'hFFFFA1B2, 1'b0, 0, 1'b0);
        apply_stimulus("lw10", 1'b0, 3'd2, 32'h10, 32'd0, 3, 4'b0000, 32'd0, 32'hA1B2C3D4, 1'b0, 0, 1'b0);
        apply_stimulus("lhu10", 1'b0, 3'd5, 32'h10, 32'd0, 3, 4'b0000, 32'd0, 32'h0000C3D4, 1'b0, 0, 1'b0);
        apply_stimulus("lb10", 1'b0, 3'd0, 32'h10, 32'd0, 3, 4'b0000, 32'd0, 32'hFFFFFFD4, 1'b0, 0, 1'b0);
        apply_stimulus("lbu11_stall", 1'b0, 3'd4, 32'h11, 32'd0, 3, 4'b0000, 32'd0, 32'h000000C3, 1'b0, 5, 1'b0);

        // Errors: no memory strobe may appear for any of them.
        pulse_snap = pulse_cnt;
        apply_stimulus("lw12_err", 1'b0, 3'd2, 32'h12, 32'd0, 1, 4'b0000, 32'd0, 32'd0, 1'b1, 0, 1'b0);
        apply_stimulus("sh11_err", 1'b1, 3'd1, 32'h11, 32'h5555, 1, 4'b0000, 32'd0, 32'd0, 1'b1, 0, 1'b0);
        apply_stimulus("ld_f3_3", 1'b0, 3'd3, 32'h10, 32'd0, 1, 4'b0000, 32'd0, 32'd0, 1'b1, 0, 1'b0);
        apply_stimulus("st_f3_4", 1'b1, 3'd4, 32'h10, 32'h1, 1, 4'b0000, 32'd0, 32'd0, 1'b1, 0, 1'b0);
        apply_stimulus("lh13_err", 1'b0, 3'd1, 32'h13, 32'd0, 1, 4'b0000, 32'd0, 32'd0, 1'b1, 0, 1'b0);
        check_output("err_no_pulse", 32'(pulse_cnt), 32'(pulse_snap));

        // Reset during the ISSUE cycle of a store.
        wait_ready("rst_mid");
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = 1'b1;
        bus.i_req_funct3 = 3'd2;
        bus.i_req_addr   = 32'h20;
        bus.i_req_wdata  = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        check_output("rst_mid_wr_en_before", 32'(bus.o_mem_wr_en), 32'hF);
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_mid_wr_en_after", 32'(bus.o_mem_wr_en), 32'd0);
        check_output("rst_mid_req_ready", 32'(bus.o_req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("rst_mid_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
            check_output("rst_mid_no_wr", 32'(bus.o_mem_wr_en), 32'd0);
        end
`ifdef LSU_ADAPTER_STATS_EN
        check_output("stat_zero_loads", stat_loads, 32'd0);
        check_output("stat_zero_stores", stat_stores, 32'd0);
        check_output("stat_zero_errs", stat_errs, 32'd0);
`endif

        // Two loads, one store, one error after reset.
        apply_stimulus("post_lw", 1'b0, 3'd2, 32'h10, 32'd0, 3, 4'b0000, 32'd0, 32'hA1B2C3D4, 1'b0, 0, 1'b0);
        apply_stimulus("post_lbu", 1'b0, 3'd4, 32'h13, 32'd0, 3, 4'b0000, 32'd0, 32'h000000A1, 1'b0, 0, 1'b0);
        apply_stimulus("post_sw", 1'b1, 3'd2, 32'h10, 32'hCAFEF00D, 2, 4'b1111, 32'hCAFEF00D, 32'd0, 1'b0, 0, 1'b0);
        apply_stimulus("post_err", 1'b0, 3'd7, 32'h10, 32'd0, 1, 4'b0000, 32'd0, 32'd0, 1'b1, 0, 1'b0);
`ifdef LSU_ADAPTER_STATS_EN
        check_output("stat_loads", stat_loads, 32'd2);
        check_output("stat_stores", stat_stores, 32'd1);
        check_output("stat_errs", stat_errs, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
